weight_row_streamer: RTL
========================

// Module: weight_row_streamer
// PURPOSE
//   Parametrised weight store for a fully-connected layer: N_ROW neurons x N_COL weights, DATA_W bits each.
//   Weights are loaded one word per cycle by (row, col) address.
//   The whole matrix is then streamed out one full row per beat, all columns in parallel.
//   Streaming uses a valid/ready handshake so the MAC array downstream can stall it.
//   Sits between the weight loader and the linear-layer MAC array.
// PARAMETERS
//   N_ROW   10  number of neurons (rows streamed per pass)
//   N_COL   10  weights per neuron (columns presented in parallel)
//   DATA_W  10  bits per weight (two's complement, opaque to this block)
//   ROW_AW  $clog2(N_ROW)  row address width (derived)
//   COL_AW  $clog2(N_COL)  column address width (derived)
// PORTS
//   clk        in   1               rising-edge clock
//   rst_n      in   1               asynchronous active-low reset
//   wr_en      in   1               write request for this cycle
//   wr_row     in   ROW_AW          write row (neuron) address
//   wr_col     in   COL_AW          write column (weight) address
//   wr_data    in   DATA_W          write data
//   wr_err     out  1               1-cycle pulse: write rejected (busy or address out of range)
//   rd_start   in   1               start a streaming pass (sampled in IDLE only)
//   rd_ready   in   1               downstream accepts the current row
//   row_valid  out  1               row_data/row_idx/row_last hold a valid row
//   row_data   out  N_COL*DATA_W    row weights; column c at [c*DATA_W +: DATA_W]
//   row_idx    out  ROW_AW          index of the row on row_data
//   row_last   out  1               current row is N_ROW-1
//   busy       out  1               pass in progress (state != IDLE or row_valid)
// BEHAVIOUR
//   Reset (async): state=IDLE, row_valid=0, row_last=0, row_idx=0, row_data=0, wr_err=0, busy=0.
//   Reset does not clear the weight array; its contents survive reset and are undefined after power-up.
//   FSM states: IDLE, STREAM.
//   - IDLE -> STREAM on rd_start. The fetch pointer is set to 0.
//   - STREAM -> IDLE when the beat with row_last is accepted (row_valid && rd_ready).
//   Output register loads mem[ptr] and ptr increments whenever the state is STREAM, ptr < N_ROW, and (!row_valid || rd_ready).
//   If a handshake completes and no further row is fetched, row_valid drops on that edge.
//   Latency: rd_start sampled at edge E0 -> row 0 valid after edge E1 (2nd edge). With rd_ready held 1, rows arrive back-to-back, N_ROW beats.
//   Stall: while row_valid && !rd_ready, row_data/row_idx/row_last are held stable.
//   rd_start is ignored while busy. rd_start on the same edge as the final accept is also ignored.
//   Writes:
//   - Accepted only when busy=0 and wr_row<N_ROW and wr_col<N_COL; mem[wr_row][wr_col] updates at the edge.
//   - Otherwise the write is dropped and wr_err=1 for the following cycle.
//   Simultaneous wr_en and rd_start in IDLE: the write is accepted, and row 0 of the pass reflects the new value.
//   Back-to-back passes: a new rd_start is legal from the first cycle busy=0. Each pass restarts at row 0.
// TESTING
//   1) Write w[r][c]=r*16+c for all 100 cells; rd_start; rd_ready=1 -> row_valid high 10 consecutive cycles from 2nd edge, row_idx 0..9, row 3 col 7 = 55, row_last only at idx 9, busy falls after.
//   2) Same pass with rd_ready toggling 1,0,0,1,... -> no row lost or duplicated, row_data stable during stall, exactly 10 handshakes.
//   3) wr_en with row=2,col=2,data=0x3FF mid-pass -> wr_err pulses 1 cycle; next pass shows w[2][2]=34 unchanged.
//   4) wr_en with row=10 or col=12 in IDLE -> wr_err pulse, no cell modified.
//   5) rst_n low during row 4 -> row_valid=0, busy=0 immediately; new rd_start streams rows 0..9 with original data.
//   6) wr_en(row 0,col 0,data 5) together with rd_start -> first beat row_data[9:0]=5; rd_start asserted during the pass is ignored.

Source files
------------

// File: rtl/weight_row_streamer.sv
// weight_row_streamer
//   Weight store for one fully-connected layer: N_ROW neurons by N_COL weights,
//   DATA_W bits per weight. The loader writes one weight per cycle, addressed by
//   (row, col). A streaming pass then sends the matrix out one full row per beat,
//   with all columns side by side. The MAC array downstream can stall the stream
//   through a valid/ready handshake.
//
// Ports
//   clk_i          rising-edge clock
//   rst_n_i        asynchronous active-low reset
//   wr_en_i        write request for this cycle
//   wr_row_i       write row (neuron) address
//   wr_col_i       write column (weight) address
//   wr_data_i      write data
//   wr_err_o       1-cycle pulse: previous write rejected (busy or out of range)
//   rd_start_i     start a streaming pass (ignored while busy)
//   rd_ready_i     downstream accepts the current row
//   row_valid_o    row_data_o/row_idx_o/row_last_o hold a valid row
//   row_data_o     row weights; column c at [c*DATA_W +: DATA_W]
//   row_idx_o      index of the row on row_data_o
//   row_last_o     current row is N_ROW-1
//   busy_o         pass in progress
//
// State   | meaning
// IDLE    | no pass active, writes allowed
// STREAM  | fetching/presenting rows until the last row is accepted

module weight_row_streamer #(
  parameter int N_ROW  = 10,
  parameter int N_COL  = 10,
  parameter int DATA_W = 10,
  parameter int ROW_AW = (N_ROW > 1) ? $clog2(N_ROW) : 1,
  parameter int COL_AW = (N_COL > 1) ? $clog2(N_COL) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      wr_en_i,
  input  logic [ROW_AW-1:0]         wr_row_i,
  input  logic [COL_AW-1:0]         wr_col_i,
  input  logic [DATA_W-1:0]         wr_data_i,
  output logic                      wr_err_o,
  input  logic                      rd_start_i,
  input  logic                      rd_ready_i,
  output logic                      row_valid_o,
  output logic [N_COL*DATA_W-1:0]   row_data_o,
  output logic [ROW_AW-1:0]         row_idx_o,
  output logic                      row_last_o,
  output logic                      busy_o
);

  // The pointer has to be able to hold N_ROW. That value means "every row
  // fetched, waiting for the final accept".
  localparam int PTR_W = $clog2(N_ROW + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic                      row_valid_q, row_valid_d;
  logic [N_COL*DATA_W-1:0]   row_data_q, row_data_d;
  logic [ROW_AW-1:0]         row_idx_q, row_idx_d;
  logic                      row_last_q, row_last_d;
  logic                      wr_err_q, wr_err_d;

  // Weight array. It has no reset, so its contents survive rst_n_i.
  logic [DATA_W-1:0]         mem_q [N_ROW][N_COL];

  logic                      busy;
  logic                      wr_in_range;
  logic                      wr_accept;
  logic                      accept;
  logic                      fetch;
  logic [ROW_AW-1:0]         rd_row;
  logic [N_COL*DATA_W-1:0]   mem_row;

  assign busy        = (state_q != IDLE) || row_valid_q;

  // Widen each address by one bit so the compare still works when N_ROW or
  // N_COL is a power of two.
  assign wr_in_range = ({1'b0, wr_row_i} < (ROW_AW+1)'(N_ROW)) &&
                       ({1'b0, wr_col_i} < (COL_AW+1)'(N_COL));
  assign wr_accept   = wr_en_i && !busy && wr_in_range;

  assign accept      = row_valid_q && rd_ready_i;
  assign fetch       = (state_q == STREAM) && (ptr_q < PTR_W'(N_ROW)) &&
                       (!row_valid_q || rd_ready_i);

  // Clamp the read index so it never goes out of range once ptr_q reaches N_ROW.
  assign rd_row      = (ptr_q < PTR_W'(N_ROW)) ? ptr_q[ROW_AW-1:0] : '0;

  always_comb begin
    mem_row = '0;
    for (int c = 0; c < N_COL; c++) begin
      mem_row[c*DATA_W +: DATA_W] = mem_q[rd_row][c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    row_valid_d = row_valid_q;
    row_data_d  = row_data_q;
    row_idx_d   = row_idx_q;
    row_last_d  = row_last_q;
    wr_err_d    = wr_en_i && !wr_accept;

    case (state_q)
      IDLE: begin
        if (rd_start_i && !busy) begin
          state_d = STREAM;
          ptr_d   = '0;
        end
      end
      STREAM: begin
        if (accept && row_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fetch reloads the output register. An accept with no fetch behind it
    // empties the output register.
    if (fetch) begin
      row_valid_d = 1'b1;
      row_data_d  = mem_row;
      row_idx_d   = rd_row;
      row_last_d  = (ptr_q == PTR_W'(N_ROW - 1));
      ptr_d       = ptr_q + PTR_W'(1);
    end else if (accept) begin
      row_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      row_idx_q   <= '0;
      row_last_q  <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      row_idx_q   <= row_idx_d;
      row_last_q  <= row_last_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign wr_err_o    = wr_err_q;
  assign row_valid_o = row_valid_q;
  assign row_data_o  = row_data_q;
  assign row_idx_o   = row_idx_q;
  assign row_last_o  = row_last_q;
  assign busy_o      = busy;

endmodule
